// File: rtl/d16_pkg.sv
// d16 decode shared definitions: instruction field layout, NOP opcode,
// and instruction-class predicates.
package d16_pkg;

    localparam int XLEN    = 16;
    localparam int REG_W   = 3;
    localparam int NREGS   = 8;
    localparam int OPC_W   = 5;
    localparam int IMM_W   = 8;
    localparam int OPC_LSB = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_LSB  = 5;
    localparam int RB_LSB  = 2;

    localparam logic [7:0] NOP_OP = 8'h00;

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [IMM_W-1:0] imm8;
    } d16_fields_t;

    function automatic d16_fields_t fields(logic [XLEN-1:0] w);
        d16_fields_t f;
        f.opc  = w[OPC_LSB +: OPC_W];
        f.rd   = w[RD_LSB +: REG_W];
        f.ra   = w[RA_LSB +: REG_W];
        f.rb   = w[RB_LSB +: REG_W];
        f.imm8 = w[0 +: IMM_W];
        return f;
    endfunction

    function automatic logic is_itype(logic [OPC_W-1:0] opc);
        return opc[OPC_W-1];
    endfunction

    // opcode 0 and the 01xxx group (stores/branches) produce no result
    function automatic logic writes_rd(logic [OPC_W-1:0] opc);
        return !(opc == '0 || opc[4:3] == 2'b01);
    endfunction

endpackage

// File: rtl/d16_regfile.sv
// 8x16 register file: one write port, two async read ports.
// D16_DECODE_BYPASS_EN forwards same-cycle writeback data to the reads.
module d16_regfile
    import d16_pkg::*;
#(
    parameter int R0_ZERO = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic [REG_W-1:0] rd_addr0,
    input  logic [REG_W-1:0] rd_addr1,
    output logic [XLEN-1:0]  rd_data0,
    output logic [XLEN-1:0]  rd_data1
);

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_ok;

    assign wr_ok = wb_en && !(R0_ZERO != 0 && wb_addr == '0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wb_addr] <= wb_data;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(
        logic [REG_W-1:0] addr
    );
        if (R0_ZERO != 0 && addr == '0) begin
            return '0;
        end
`ifdef D16_DECODE_BYPASS_EN
        if (wb_en && wb_addr == addr) begin
            return wb_data;
        end
`endif
        return mem[addr];
    endfunction

    always_comb begin
        rd_data0 = rd_port(rd_addr0);
        rd_data1 = rd_port(rd_addr1);
    end

endmodule

// File: rtl/d16_decode.sv
// d16 decode/issue stage: IR, register file, scoreboard, hazard bubbles.
// Optional same-cycle writeback forwarding: D16_DECODE_BYPASS_EN.
module d16_decode
    import d16_pkg::*;
#(
    parameter logic [7:0] NOP_OP  = d16_pkg::NOP_OP,
    parameter int         R0_ZERO = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [XLEN-1:0]  in_instr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             ex_stall,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic [7:0]       op,
    output logic [XLEN-1:0]  a,
    output logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  c,
    output logic             en
);

    logic             ir_valid;
    logic [XLEN-1:0]  ir;
    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_n;
    d16_fields_t      f;
    logic             itype;
    logic             wr_rd;
    logic             busy0;
    logic             busy1;
    logic             hazard;
    logic             issue;
    logic [REG_W-1:0] src0;
    logic [XLEN-1:0]  rdata0;
    logic [XLEN-1:0]  rdata1;

    assign f     = fields(ir);
    assign itype = is_itype(f.opc);
    assign wr_rd = writes_rd(f.opc)
                && !(R0_ZERO != 0 && f.rd == '0);
    assign src0  = itype ? f.rd : f.ra;

`ifdef D16_DECODE_BYPASS_EN
    logic fwd0;
    logic fwd1;
    assign fwd0  = wb_en && wb_addr == src0;
    assign fwd1  = wb_en && wb_addr == f.rb;
    assign busy0 = sb[src0] && !fwd0;
    assign busy1 = !itype && sb[f.rb] && !fwd1;
`else
    assign busy0 = sb[src0];
    assign busy1 = !itype && sb[f.rb];
`endif

    assign hazard   = ir_valid && (busy0 || busy1);
    assign issue    = ir_valid && !hazard
                   && !ex_stall && !flush;
    assign en       = !ex_stall;
    assign in_ready = !ir_valid || issue || flush;

    d16_regfile #(
        .R0_ZERO (R0_ZERO)
    ) u_rf (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr0  (src0),
        .rd_addr1  (f.rb),
        .rd_data0  (rdata0),
        .rd_data1  (rdata1)
    );

    always_comb begin
        op = NOP_OP;
        a  = '0;
        b  = '0;
        c  = '0;
        if (issue) begin
            op = {3'b000, f.opc};
            a  = rdata0;
            b  = itype ? {{8{f.imm8[7]}}, f.imm8} : rdata1;
            c  = {13'd0, f.rd};
        end
    end

    // clear first so a same-cycle new producer keeps the bit set
    always_comb begin
        sb_n = sb;
        if (wb_en) begin
            sb_n[wb_addr] = 1'b0;
        end
        if (issue && wr_rd) begin
            sb_n[f.rd] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ir_valid <= 1'b0;
            ir       <= '0;
            sb       <= '0;
        end else begin
            sb <= sb_n;
            if (in_valid && in_ready) begin
                ir       <= in_instr;
                ir_valid <= 1'b1;
            end else if (issue || flush) begin
                ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_d16_decode.sv
// Randomized + directed bench for d16_decode against a spec-level model.
module tb_d16_decode;

    localparam bit R0Z = 1'b1;
`ifdef D16_DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] in_instr  = '0;
    logic        in_valid  = 1'b0;
    logic        flush     = 1'b0;
    logic        ex_stall  = 1'b0;
    logic        wb_en     = 1'b0;
    logic [2:0]  wb_addr   = '0;
    logic [15:0] wb_data   = '0;
    logic        in_ready;
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        en;

    d16_decode #(
        .NOP_OP  (8'h00),
        .R0_ZERO (1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_instr  (in_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .ex_stall  (ex_stall),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .en        (en)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_reg [8];
    bit          m_sb  [8];
    bit          m_irv;
    logic [15:0] m_ir;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sb_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_sb[i];
        return v;
    endfunction

    function automatic bit fwd(int r);
        return BYP && wb_en && int'(wb_addr) == r;
    endfunction

    function automatic logic [15:0] rval(int r);
        if (R0Z && r == 0) return 16'h0000;
        if (fwd(r)) return wb_data;
        return m_reg[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = '0;
            m_sb[i]  = 1'b0;
        end
        m_irv = 1'b0;
        m_ir  = '0;
    endtask

    task automatic settle();
        #3;
    endtask

    // compare this cycle's outputs, then step the model across the edge
    task automatic advance();
        int opc, rd, ra, rb, imm;
        bit ity, wrt, haz, iss, rdy;
        int srcs[$];
        logic [7:0]  eop;
        logic [15:0] ea, eb, ec;
        logic [15:0] n_reg [8];
        bit          n_sb  [8];
        bit          n_irv;
        logic [15:0] n_ir;

        opc = int'(m_ir) / 2048;
        rd  = (int'(m_ir) / 256) % 8;
        ra  = (int'(m_ir) / 32) % 8;
        rb  = (int'(m_ir) / 4) % 8;
        imm = int'(m_ir) % 256;
        ity = opc >= 16;
        wrt = opc != 0 && !(opc >= 8 && opc < 16);
        if (ity) srcs = '{rd};
        else     srcs = '{ra, rb};
        haz = 1'b0;
        foreach (srcs[i])
            if (m_sb[srcs[i]] && !fwd(srcs[i])) haz = 1'b1;
        haz = haz && m_irv;
        iss = m_irv && !haz && !ex_stall && !flush;
        rdy = !m_irv || iss || flush;
        eop = 8'h00; ea = '0; eb = '0; ec = '0;
        if (iss) begin
            eop = 8'(opc);
            ec  = 16'(rd);
            ea  = rval(srcs[0]);
            if (ity) eb = (imm >= 128) ? 16'(imm - 256) : 16'(imm);
            else     eb = rval(rb);
        end

        check("en", en, !ex_stall);
        check("in_ready", in_ready, rdy);
        if (!ex_stall) begin
            check("op", op, eop);
            check("a", a, ea);
            check("b", b, eb);
            check("c", c, ec);
        end

        n_reg = m_reg;
        n_sb  = m_sb;
        if (wb_en && !(R0Z && wb_addr == 3'd0))
            n_reg[wb_addr] = wb_data;
        if (wb_en) n_sb[wb_addr] = 1'b0;
        if (iss && wrt && !(R0Z && rd == 0)) n_sb[rd] = 1'b1;
        n_irv = m_irv;
        n_ir  = m_ir;
        if (in_valid && rdy) begin
            n_irv = 1'b1;
            n_ir  = in_instr;
        end else if (iss || flush) begin
            n_irv = 1'b0;
        end

        @(posedge sys_clk);
        #1;
        m_reg = n_reg;
        m_sb  = n_sb;
        m_irv = n_irv;
        m_ir  = n_ir;
        check("scoreboard", dut.sb, sb_vec());
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        ex_stall = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic rand_inputs();
        int busy[$];
        in_valid = $urandom_range(0, 3) != 0;
        in_instr = 16'($urandom);
        flush    = $urandom_range(0, 15) == 0;
        ex_stall = $urandom_range(0, 7) == 0;
        wb_en    = $urandom_range(0, 1) == 1;
        wb_data  = 16'($urandom);
        for (int i = 0; i < 8; i++) if (m_sb[i]) busy.push_back(i);
        if (busy.size() > 0 && $urandom_range(0, 3) != 0)
            wb_addr = 3'(busy[$urandom_range(0, busy.size() - 1)]);
        else
            wb_addr = 3'($urandom_range(0, 7));
    endtask

    logic [15:0] i_r3w, i_r3r, i_neg, i_pos;

    initial begin
        i_r3w = {5'h01, 3'd3, 3'd1, 3'd2, 2'b00};
        i_r3r = {5'h02, 3'd4, 3'd3, 3'd0, 2'b00};
        i_neg = {5'h10, 3'd5, 8'hF0};
        i_pos = {5'h11, 3'd6, 8'h7F};
        model_reset();

        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        sys_rst_n = 1'b1;
        settle();
        check("rst_op", op, 8'h00);
        check("rst_abc", {a, b}, 32'h0);
        check("rst_c", c, 16'h0);
        check("rst_en", en, 1);
        check("rst_sb", dut.sb, 8'h00);
        advance();

        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'd5;
        cycle();
        wb_addr = 3'd2; wb_data = 16'd7;
        cycle();
        wb_en = 1'b0;

        in_valid = 1'b1; in_instr = i_r3w;
        cycle();
        in_instr = i_r3r;
        settle();
        check("ind_op", op, 8'h01);
        check("ind_a", a, 16'd5);
        check("ind_b", b, 16'd7);
        check("ind_c", c, 16'd3);
        advance();
        check("ind_sb3", dut.sb[3], 1);
        in_valid = 1'b0;
        settle();
        check("raw_bubble", op, 8'h00);
        check("raw_ready", in_ready, 0);
        advance();
        cycle();
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h00AA;
        settle();
        if (BYP) check("byp_a", a, 16'h00AA);
        else     check("nobyp_op", op, 8'h00);
        advance();
        wb_en = 1'b0;
        settle();
        if (!BYP) check("late_a", a, 16'h00AA);
        advance();

        in_valid = 1'b1; in_instr = i_neg;
        cycle();
        in_valid = 1'b0;
        settle();
        check("sext_b", b, 16'hFFF0);
        check("sext_op", op, 8'h10);
        advance();

        in_valid = 1'b1; in_instr = i_r3w;
        cycle();
        cycle();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        cycle();
        wb_en = 1'b0;
        check("setclr_sb3", dut.sb[3], 1);

        in_valid = 1'b1; in_instr = i_r3r;
        cycle();
        in_valid = 1'b0;
        cycle();
        flush = 1'b1;
        settle();
        check("flush_ready", in_ready, 1);
        advance();
        flush = 1'b0;
        check("flush_sb3", dut.sb[3], 1);
        cycle();

        ex_stall = 1'b1; in_valid = 1'b1; in_instr = i_pos;
        cycle();
        settle();
        check("stall_en", en, 0);
        check("stall_ready", in_ready, 0);
        advance();
        ex_stall = 1'b0; in_valid = 1'b0;
        settle();
        check("stall_op", op, 8'h11);
        check("stall_b", b, 16'h007F);
        advance();

        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                idle();
                sys_rst_n = 1'b0;
                #2;
                check("midrst_op", op, 8'h00);
                check("midrst_ready", in_ready, 1);
                check("midrst_sb", dut.sb, 8'h00);
                sys_rst_n = 1'b1;
                model_reset();
            end
            rand_inputs();
            cycle();
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule
